// File: rtl/score_keeper.sv
// score_keeper: pong-style score/serve FSM with edge-detected start and point inputs.
module score_keeper #(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       point_1,
    input  logic       point_2,
    output logic [3:0] score_1,
    output logic [3:0] score_2,
    output logic       ball_run,
    output logic [1:0] state,
    output logic [1:0] winner
);
    typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;
    localparam logic [3:0] WIN   = 4'(WIN_SCORE);
    localparam logic [7:0] DELAY = 8'(SERVE_DELAY);

    state_t     r_state, w_next;
    logic [7:0] r_cnt, w_cnt;
    logic [3:0] r_s1, r_s2, w_s1, w_s2, w_inc1, w_inc2;
    logic [1:0] r_win, w_win;
    logic       r_run, r_start_d, r_p1_d, r_p2_d;
    logic       w_start_ev, w_p1_ev, w_p2_ev;

    assign w_start_ev = start & ~r_start_d;
    assign w_p1_ev    = point_1 & ~r_p1_d;
    assign w_p2_ev    = point_2 & ~r_p2_d;
    assign w_inc1     = (r_s1 == 4'd9) ? 4'd9 : r_s1 + 4'd1;
    assign w_inc2     = (r_s2 == 4'd9) ? 4'd9 : r_s2 + 4'd1;

    always_comb begin
        w_next = r_state;
        w_cnt  = r_cnt;
        w_s1   = r_s1;
        w_s2   = r_s2;
        w_win  = r_win;
        case (r_state)
            IDLE: if (w_start_ev) begin
                w_next = SERVE;
                w_cnt  = DELAY;
            end
            SERVE: if (r_cnt == 8'd0) w_next = PLAY;
                   else if (frame_tick) w_cnt = r_cnt - 8'd1;
            PLAY: begin
                // a tied point is thrown away and the rally is re-served
                if (w_p1_ev && w_p2_ev) begin
                    w_next = SERVE;
                    w_cnt  = DELAY;
                end else if (w_p1_ev) begin
                    w_s1   = w_inc1;
                    w_next = (w_inc1 == WIN) ? OVER : SERVE;
                    w_win  = (w_inc1 == WIN) ? 2'd1 : r_win;
                    w_cnt  = DELAY;
                end else if (w_p2_ev) begin
                    w_s2   = w_inc2;
                    w_next = (w_inc2 == WIN) ? OVER : SERVE;
                    w_win  = (w_inc2 == WIN) ? 2'd2 : r_win;
                    w_cnt  = DELAY;
                end
            end
            OVER: if (w_start_ev) begin
                w_next = IDLE;
                w_s1   = 4'd0;
                w_s2   = 4'd0;
                w_win  = 2'd0;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= 8'd0;
            r_s1      <= 4'd0;
            r_s2      <= 4'd0;
            r_win     <= 2'd0;
            r_run     <= 1'b0;
            r_start_d <= 1'b0;
            r_p1_d    <= 1'b0;
            r_p2_d    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt;
            r_s1      <= w_s1;
            r_s2      <= w_s2;
            r_win     <= w_win;
            r_run     <= (w_next == PLAY);
            r_start_d <= start;
            r_p1_d    <= point_1;
            r_p2_d    <= point_2;
        end
    end

    assign score_1  = r_s1;
    assign score_2  = r_s2;
    assign ball_run = r_run;
    assign state    = r_state;
    assign winner   = r_win;
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed and random checks of score_keeper against a behavioural game model.
module tb_score_keeper;
    localparam int WIN = 7;
    localparam int SD  = 3;

    logic       clk = 1'b0, reset = 1'b1, frame_tick = 1'b0, start = 1'b0;
    logic       point_1 = 1'b0, point_2 = 1'b0;
    logic [3:0] score_1, score_2;
    logic       ball_run;
    logic [1:0] state, winner;
    int total = 0, bad = 0;

    score_keeper #(.WIN_SCORE(WIN), .SERVE_DELAY(SD)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
        .point_1(point_1), .point_2(point_2), .score_1(score_1), .score_2(score_2),
        .ball_run(ball_run), .state(state), .winner(winner)
    );

    always #5 clk = ~clk;

    // game model: phase 0 idle, 1 serving, 2 rally, 3 game over
    int m_ph = 0, m_s1 = 0, m_s2 = 0, m_win = 0, m_wait = 0;
    bit m_ps = 0, m_p1 = 0, m_p2 = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ph = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_wait = 0;
            m_ps = 0; m_p1 = 0; m_p2 = 0;
        end else begin
            bit se, e1, e2;
            se = start && !m_ps;
            e1 = point_1 && !m_p1;
            e2 = point_2 && !m_p2;
            if (m_ph == 0) begin
                if (se) begin m_ph = 1; m_wait = SD; end
            end else if (m_ph == 1) begin
                if (m_wait == 0) m_ph = 2;
                else if (frame_tick) m_wait--;
            end else if (m_ph == 2) begin
                if (e1 && e2) begin m_ph = 1; m_wait = SD; end
                else if (e1 || e2) begin
                    if (e1) m_s1 = (m_s1 + 1 > 9) ? 9 : m_s1 + 1;
                    else    m_s2 = (m_s2 + 1 > 9) ? 9 : m_s2 + 1;
                    if ((e1 ? m_s1 : m_s2) == WIN) begin m_ph = 3; m_win = e1 ? 1 : 2; end
                    else begin m_ph = 1; m_wait = SD; end
                end
            end else if (se) begin
                m_ph = 0; m_s1 = 0; m_s2 = 0; m_win = 0;
            end
            m_ps = start; m_p1 = point_1; m_p2 = point_2;
        end
    end

    task automatic chk(input string n, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_state", int'(state), m_ph);
        chk("model_score_1", int'(score_1), m_s1);
        chk("model_score_2", int'(score_2), m_s2);
        chk("model_winner", int'(winner), m_win);
        chk("model_ball_run", int'(ball_run), int'(m_ph == 2));
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic go_play();
        int n = 0;
        frame_tick = 1'b1;
        while (state != 2'd2 && n < 600) begin cyc(); n++; end
        frame_tick = 1'b0;
        if (n >= 600) chk("go_play_timeout", int'(state), 2);
    endtask

    task automatic pulse(input bit p1, input bit p2);
        point_1 = p1; point_2 = p2;
        cyc();
        point_1 = 1'b0; point_2 = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b0;
        repeat (3) cyc();
        chk("rst_state", int'(state), 0);
        chk("rst_scores", int'({score_1, score_2}), 0);
        chk("rst_ball_run", int'(ball_run), 0);
        reset = 1'b1;
        repeat (3) cyc();
        chk("idle_hold", int'(state), 0);
        start = 1'b1;
        cyc();
        chk("serve_entry", int'(state), 1);
        frame_tick = 1'b1;
        repeat (3) cyc();
        chk("serve_after_3_ticks", int'(state), 1);
        frame_tick = 1'b0;
        cyc();
        chk("play_state", int'(state), 2);
        chk("play_ball_run", int'(ball_run), 1);
        point_1 = 1'b1;
        cyc();
        chk("p1_once", int'(score_1), 1);
        chk("p1_serve", int'(state), 1);
        chk("p1_ball_stop", int'(ball_run), 0);
        repeat (4) cyc();
        chk("p1_held", int'(score_1), 1);
        point_1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            go_play();
            pulse(0, 1);
        end
        chk("s2_six", int'(score_2), 6);
        go_play();
        pulse(0, 1);
        chk("win_score_2", int'(score_2), 7);
        chk("win_state", int'(state), 3);
        chk("win_winner", int'(winner), 2);
        pulse(1, 0);
        chk("over_ignore_pt", int'(score_1), 1);
        chk("over_hold", int'(state), 3);
        start = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        chk("over_to_idle", int'(state), 0);
        chk("over_clear", int'({score_1, score_2, winner}), 0);
        repeat (3) cyc();
        chk("start_held_idle", int'(state), 0);
        start = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        chk("repress_serve", int'(state), 1);
        start = 1'b0;
        go_play();
        pulse(1, 1);
        chk("tie_scores", int'({score_1, score_2}), 0);
        chk("tie_serve", int'(state), 1);
        for (int i = 0; i < 3; i++) begin
            go_play();
            pulse(1, 0);
        end
        go_play();
        chk("pre_rst_s1", int'(score_1), 3);
        reset = 1'b0;
        #1;
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_s1", int'(score_1), 0);
        chk("async_rst_run", int'(ball_run), 0);
        cyc();
        reset = 1'b1;
        repeat (2) cyc();
        chk("post_rst_idle", int'(state), 0);
        for (int i = 0; i < 4000; i++) begin
            start      = ($urandom % 6) == 0;
            frame_tick = $urandom % 2;
            point_1    = ($urandom % 4) == 0;
            point_2    = ($urandom % 4) == 0;
            reset      = ($urandom % 400) != 0;
            cyc();
        end
        reset = 1'b1;
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
